// File: rtl/commit_pkg.sv
// Shared constants, entry-kind tags and state encoding for the in-order commit controller.
package commit_pkg;
    localparam int IDX_W_DEF = 5;
    localparam int XLEN_DEF  = 32;

    localparam logic [1:0] TAG_ALU = 2'b00;
    localparam logic [1:0] TAG_BR  = 2'b01;
    localparam logic [1:0] TAG_JMP = 2'b10;
    localparam logic [1:0] TAG_ST  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    // ALU results and jump link values both land in the register file.
    function automatic logic tag_writes_rf(input logic [1:0] tag);
        return (tag == TAG_ALU) || (tag == TAG_JMP);
    endfunction

    function automatic logic tag_can_redirect(input logic [1:0] tag);
        return (tag == TAG_BR) || (tag == TAG_JMP);
    endfunction
endpackage

// File: rtl/commit_ctrl.sv
// In-order retirement: pops the ROB head, writes the register file one cycle later,
// holds stores until memory acks, and raises a one-cycle flush with redirect PC on mispredicts.
module commit_ctrl
    import commit_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             commit_en_i,
    input  logic [IDX_W-1:0] commit_id_i,
    input  logic [4:0]       commit_regaddr_i,
    input  logic [XLEN-1:0]  commit_data_i,
    input  logic [XLEN-1:0]  commit_pc_i,
    input  logic [1:0]       commit_branch_tag_i,
    input  logic             commit_cond_i,
    output logic             commit_rdy_o,
    output logic             rf_we_o,
    output logic [4:0]       rf_waddr_o,
    output logic [XLEN-1:0]  rf_wdata_o,
    output logic [IDX_W-1:0] rf_wid_o,
    output logic             st_req_o,
    output logic [IDX_W-1:0] st_id_o,
    input  logic             st_ack_i,
    output logic             flush_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [31:0]      retired_cnt_o,
    output logic [15:0]      flush_cnt_o
);

    state_t           state_q, state_d;
    logic             pop;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
    logic [IDX_W-1:0] rf_wid_q, rf_wid_d;
    logic             st_req_q, st_req_d;
    logic [IDX_W-1:0] st_id_q, st_id_d;
    logic             flush_q, flush_d;
    logic [XLEN-1:0]  redirect_q, redirect_d;
    logic [31:0]      retired_q, retired_d;
    logic [15:0]      flush_cnt_q, flush_cnt_d;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        rf_wid_d    = rf_wid_q;
        st_req_d    = st_req_q;
        st_id_d     = st_id_q;
        flush_d     = 1'b0;
        redirect_d  = redirect_q;

        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    if (commit_en_i) begin
                        if (commit_branch_tag_i == TAG_ST) begin
                            st_req_d = 1'b1;
                            st_id_d  = commit_id_i;
                            state_d  = ST_WAIT;
                        end else begin
                            pop = 1'b1;
                            if (tag_writes_rf(commit_branch_tag_i) && (commit_regaddr_i != 5'd0)) begin
                                rf_we_d    = 1'b1;
                                rf_waddr_d = commit_regaddr_i;
                                rf_wdata_d = commit_data_i;
                                rf_wid_d   = commit_id_i;
                            end
                            if (tag_can_redirect(commit_branch_tag_i) && commit_cond_i) begin
                                flush_d    = 1'b1;
                                redirect_d = commit_pc_i;
                                state_d    = FLUSH;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (st_ack_i) begin
                        pop      = 1'b1;
                        st_req_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
                // The head bundle is stale while the ROB clears, so it is never looked at here.
                FLUSH:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        retired_d   = retired_q + 32'(pop);
        flush_cnt_d = (flush_d && (flush_cnt_q != 16'hFFFF)) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    end

    assign commit_rdy_o = pop && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            rf_wid_q    <= '0;
            st_req_q    <= 1'b0;
            st_id_q     <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            retired_q   <= '0;
            flush_cnt_q <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_wid_q    <= rf_wid_d;
            st_req_q    <= st_req_d;
            st_id_q     <= st_id_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            retired_q   <= retired_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign rf_we_o       = rf_we_q;
    assign rf_waddr_o    = rf_waddr_q;
    assign rf_wdata_o    = rf_wdata_q;
    assign rf_wid_o      = rf_wid_q;
    assign st_req_o      = st_req_q;
    assign st_id_o       = st_id_q;
    assign flush_o       = flush_q;
    assign redirect_pc_o = redirect_q;
    assign retired_cnt_o = retired_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Self-checking bench for commit_ctrl: directed scenarios plus a randomized run against a retirement model.
module tb_commit_ctrl;
    localparam int IDX_W = 5;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rdy = 1'b1;
    logic             commit_en_i = 1'b0;
    logic [IDX_W-1:0] commit_id_i = '0;
    logic [4:0]       commit_regaddr_i = '0;
    logic [XLEN-1:0]  commit_data_i = '0;
    logic [XLEN-1:0]  commit_pc_i = '0;
    logic [1:0]       commit_branch_tag_i = '0;
    logic             commit_cond_i = 1'b0;
    logic             st_ack_i = 1'b0;
    logic             commit_rdy_o, rf_we_o, st_req_o, flush_o;
    logic [4:0]       rf_waddr_o;
    logic [XLEN-1:0]  rf_wdata_o, redirect_pc_o;
    logic [IDX_W-1:0] rf_wid_o, st_id_o;
    logic [31:0]      retired_cnt_o;
    logic [15:0]      flush_cnt_o;

    int checks = 0;
    int errors = 0;

    commit_ctrl #(.IDX_W(IDX_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .commit_en_i(commit_en_i), .commit_id_i(commit_id_i),
        .commit_regaddr_i(commit_regaddr_i), .commit_data_i(commit_data_i),
        .commit_pc_i(commit_pc_i), .commit_branch_tag_i(commit_branch_tag_i),
        .commit_cond_i(commit_cond_i), .commit_rdy_o(commit_rdy_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .rf_wid_o(rf_wid_o), .st_req_o(st_req_o), .st_id_o(st_id_o),
        .st_ack_i(st_ack_i), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
        .retired_cnt_o(retired_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: what the architectural side should have seen so far.
    bit               m_store_out;   // a store is waiting for its ack
    bit               m_flushing;    // this cycle is the redirect cycle
    bit               m_rf_we;
    logic [4:0]       m_waddr;
    logic [XLEN-1:0]  m_wdata, m_pc;
    logic [IDX_W-1:0] m_wid, m_st_id;
    int unsigned      m_ret;
    int unsigned      m_fcnt;

    task automatic model_reset();
        m_store_out = 0; m_flushing = 0; m_rf_we = 0;
        m_waddr = '0; m_wdata = '0; m_pc = '0; m_wid = '0; m_st_id = '0;
        m_ret = 0; m_fcnt = 0;
    endtask

    function automatic bit exp_pop();
        if (!rst_n || !rdy || m_flushing) return 0;
        if (m_store_out) return st_ack_i;
        return commit_en_i && (commit_branch_tag_i != 2'b11);
    endfunction

    task automatic model_edge();
        bit pop, fresh, writes, redirects;
        if (!rdy) return;
        pop       = exp_pop();
        fresh     = !m_flushing && !m_store_out && commit_en_i;
        writes    = fresh && (commit_branch_tag_i == 2'b00 || commit_branch_tag_i == 2'b10)
                    && commit_regaddr_i != 0;
        redirects = fresh && (commit_branch_tag_i == 2'b01 || commit_branch_tag_i == 2'b10)
                    && commit_cond_i;
        m_rf_we = writes;
        if (writes) begin
            m_waddr = commit_regaddr_i; m_wdata = commit_data_i; m_wid = commit_id_i;
        end
        if (redirects) begin
            m_pc = commit_pc_i;
            if (m_fcnt < 65535) m_fcnt++;
        end
        if (fresh && commit_branch_tag_i == 2'b11) begin
            m_store_out = 1; m_st_id = commit_id_i;
        end else if (m_store_out && st_ack_i) begin
            m_store_out = 0;
        end
        m_flushing = redirects;
        m_ret      = m_ret + (pop ? 1 : 0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit en, input int id, input int ra, input logic [31:0] d,
                         input logic [31:0] pc, input int tag, input bit cond);
        commit_en_i = en; commit_id_i = IDX_W'(id); commit_regaddr_i = 5'(ra);
        commit_data_i = d; commit_pc_i = pc; commit_branch_tag_i = 2'(tag); commit_cond_i = cond;
    endtask

    task automatic do_reset();
        rst_n = 0; rdy = 1; st_ack_i = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(1, 3, 4, 32'hAA, 32'h10, 0, 0);
        #1;
        checks++; if (commit_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_pop got %b want 0", commit_rdy_o); end
        checks++;
        if ({rf_we_o, st_req_o, flush_o, rf_waddr_o, rf_wdata_o, rf_wid_o, st_id_o, redirect_pc_o} !== '0) begin
            errors++; $display("FAIL reset_outputs got we=%b st=%b fl=%b wa=%0d wd=%h pc=%h", rf_we_o, st_req_o, flush_o, rf_waddr_o, rf_wdata_o, redirect_pc_o);
        end
        checks++; if (retired_cnt_o !== 32'd0 || flush_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", retired_cnt_o, flush_cnt_o); end
    endtask

    task automatic test_alu_stream();
        int ras[3]  = '{5, 6, 0};
        int dats[3] = '{32'h11, 32'h22, 32'h33};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, i + 1, ras[i], dats[i], 0, 0, 0);
            #1;
            checks++; if (commit_rdy_o !== 1'b1) begin errors++; $display("FAIL alu_pop%0d got %b want 1", i, commit_rdy_o); end
            step();
            checks++;
            if (rf_we_o !== (ras[i] != 0) || (ras[i] != 0 && (rf_waddr_o !== 5'(ras[i]) || rf_wdata_o !== dats[i] || rf_wid_o !== IDX_W'(i + 1)))) begin
                errors++; $display("FAIL alu_write%0d got we=%b x%0d=%h id=%0d want x%0d=%h", i, rf_we_o, rf_waddr_o, rf_wdata_o, rf_wid_o, ras[i], dats[i]);
            end
        end
        checks++; if (retired_cnt_o !== 32'd3) begin errors++; $display("FAIL alu_retired got %0d want 3", retired_cnt_o); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        drive(1, 2, 0, 0, 32'h0000_1040, 1, 1);
        #1;
        checks++; if (commit_rdy_o !== 1'b1) begin errors++; $display("FAIL br_pop got %b want 1", commit_rdy_o); end
        step();
        checks++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h1040 || rf_we_o !== 1'b0) begin errors++; $display("FAIL br_flush got fl=%b pc=%h we=%b want 1/1040/0", flush_o, redirect_pc_o, rf_we_o); end
        checks++; if (commit_rdy_o !== 1'b0) begin errors++; $display("FAIL br_stale_pop got %b want 0", commit_rdy_o); end
        checks++; if (flush_cnt_o !== 16'd1) begin errors++; $display("FAIL br_flush_cnt got %0d want 1", flush_cnt_o); end
        step();
        checks++; if (flush_o !== 1'b0 || commit_rdy_o !== 1'b1) begin errors++; $display("FAIL br_after got fl=%b pop=%b want 0/1", flush_o, commit_rdy_o); end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_store();
        int hi = 0;
        do_reset();
        drive(1, 7, 9, 32'h55, 0, 3, 0);
        #1;
        checks++; if (commit_rdy_o !== 1'b0) begin errors++; $display("FAIL st_detect_pop got %b want 0", commit_rdy_o); end
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, $urandom_range(0, 31), $urandom_range(1, 31), $urandom, $urandom, $urandom_range(0, 3), 1);
            st_ack_i = (i == 3);
            #1;
            checks++; if (commit_rdy_o !== (i == 3)) begin errors++; $display("FAIL st_pop%0d got %b want %b", i, commit_rdy_o, i == 3); end
            checks++; if (st_id_o !== 5'd7 || rf_we_o !== 1'b0) begin errors++; $display("FAIL st_hold%0d got id=%0d we=%b want 7/0", i, st_id_o, rf_we_o); end
            if (st_req_o) hi++;
            step();
        end
        st_ack_i = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (hi !== 4 || st_req_o !== 1'b0) begin errors++; $display("FAIL st_req_len got %0d cycles req=%b want 4/0", hi, st_req_o); end
        checks++; if (retired_cnt_o !== 32'd1) begin errors++; $display("FAIL st_retired got %0d want 1", retired_cnt_o); end
    endtask

    task automatic test_jump();
        do_reset();
        drive(1, 4, 1, 32'h0000_2004, 32'h0000_3000, 2, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd1 || rf_wdata_o !== 32'h2004) begin errors++; $display("FAIL jmp_link got we=%b x%0d=%h want x1=2004", rf_we_o, rf_waddr_o, rf_wdata_o); end
        checks++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h3000) begin errors++; $display("FAIL jmp_flush got fl=%b pc=%h want 1/3000", flush_o, redirect_pc_o); end
    endtask

    task automatic test_rdy_stall();
        do_reset();
        drive(1, 1, 5, 32'hA5, 0, 0, 0);
        step();
        rdy = 0;
        drive(1, 2, 7, 32'hB6, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (commit_rdy_o !== 1'b0) begin errors++; $display("FAIL stall_pop%0d got %b want 0", i, commit_rdy_o); end
            step();
            checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || retired_cnt_o !== 32'd1) begin errors++; $display("FAIL stall_hold%0d got we=%b x%0d cnt=%0d want 1/5/1", i, rf_we_o, rf_waddr_o, retired_cnt_o); end
        end
        rdy = 1;
        #1;
        checks++; if (commit_rdy_o !== 1'b1) begin errors++; $display("FAIL stall_resume got %b want 1", commit_rdy_o); end
        step();
        checks++; if (rf_waddr_o !== 5'd7 || rf_wdata_o !== 32'hB6 || retired_cnt_o !== 32'd2) begin errors++; $display("FAIL stall_after got x%0d=%h cnt=%0d want x7=b6/2", rf_waddr_o, rf_wdata_o, retired_cnt_o); end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        drive(1, 3, 0, 0, 0, 3, 0);
        step();
        rdy = 0; st_ack_i = 1;
        #1;
        checks++; if (commit_rdy_o !== 1'b0) begin errors++; $display("FAIL ack_in_stall_pop got %b want 0", commit_rdy_o); end
        step();
        rdy = 1; st_ack_i = 0;
        step();
        checks++; if (st_req_o !== 1'b1 || st_id_o !== 5'd3) begin errors++; $display("FAIL ack_ignored got req=%b id=%0d want 1/3", st_req_o, st_id_o); end
        drive(1, 1, 2, 32'h9, 0, 0, 0);
        rst_n = 0;
        #1;
        checks++; if (st_req_o !== 1'b0 || commit_rdy_o !== 1'b0 || retired_cnt_o !== 32'd0) begin errors++; $display("FAIL mid_reset got req=%b pop=%b cnt=%0d want 0/0/0", st_req_o, commit_rdy_o, retired_cnt_o); end
        model_reset();
        rst_n = 1;
        #1;
        checks++; if (commit_rdy_o !== 1'b1) begin errors++; $display("FAIL mid_reset_idle got %b want 1", commit_rdy_o); end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 31), $urandom_range(0, 31), $urandom,
                  $urandom, $urandom_range(0, 3), $urandom_range(0, 1));
            st_ack_i = $urandom_range(0, 9) < 3;
            rdy      = $urandom_range(0, 19) < 17;
            #1;
            checks++; if (commit_rdy_o !== exp_pop()) begin errors++; $display("FAIL rnd_pop c%0d got %b want %b", cyc, commit_rdy_o, exp_pop()); end
            step();
            checks++;
            if (rf_we_o !== m_rf_we || rf_waddr_o !== m_waddr || rf_wdata_o !== m_wdata || rf_wid_o !== m_wid) begin
                errors++; $display("FAIL rnd_rf c%0d got %b x%0d=%h id%0d want %b x%0d=%h id%0d", cyc, rf_we_o, rf_waddr_o, rf_wdata_o, rf_wid_o, m_rf_we, m_waddr, m_wdata, m_wid);
            end
            checks++;
            if (st_req_o !== m_store_out || st_id_o !== m_st_id) begin
                errors++; $display("FAIL rnd_st c%0d got %b/%0d want %b/%0d", cyc, st_req_o, st_id_o, m_store_out, m_st_id);
            end
            checks++;
            if (flush_o !== m_flushing || redirect_pc_o !== m_pc) begin
                errors++; $display("FAIL rnd_flush c%0d got %b/%h want %b/%h", cyc, flush_o, redirect_pc_o, m_flushing, m_pc);
            end
            checks++;
            if (retired_cnt_o !== m_ret || flush_cnt_o !== 16'(m_fcnt)) begin
                errors++; $display("FAIL rnd_cnt c%0d got %0d/%0d want %0d/%0d", cyc, retired_cnt_o, flush_cnt_o, m_ret, m_fcnt);
            end
        end
        rdy = 1; st_ack_i = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_branch_flush();
        test_store();
        test_jump();
        test_rdy_stall();
        test_reset_mid_store();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
